pixel_stream_out: RTL
=====================

PIXEL_STREAM_OUT -- requirements
Module: pixel_stream_out

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 512, output pixels per line, at least 2.
REQ-003 The block SHALL have parameter IMG_H, default 512, output lines per frame, at least 2.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, buffer entries, a power of 2 and at least 4.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port srst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port pixel_data_i, input, DATA_W bits: pixel from the convolution stage.
REQ-008 The block SHALL have port pixel_valid_i, input, 1 bit: pixel_data_i is valid this cycle; there is no backpressure to the source.
REQ-009 The block SHALL have port data_o, output, DATA_W bits: pixel at the FIFO head.
REQ-010 The block SHALL have port valid_o, output, 1 bit: data_o and the frame flags are valid.
REQ-011 The block SHALL have port ready_i, input, 1 bit: the consumer accepts data; a transfer occurs when valid_o and ready_i are both 1.
REQ-012 The block SHALL have ports sof_o, eol_o and eof_o, outputs, 1 bit each: start-of-frame, end-of-line and end-of-frame markers, qualified by valid_o.
REQ-013 The block SHALL have port level_o, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-014 The block SHALL have port almost_full_o, output, 1 bit: high when level_o is at least FIFO_DEPTH-2.
REQ-015 The block SHALL have port overflow_o, output, 1 bit: sticky flag set when a pixel was dropped.

Function
REQ-016 Push rule: a push occurs when pixel_valid_i=1 and either the FIFO is not full or a transfer occurs in the same cycle.
REQ-017 Drop rule: if pixel_valid_i=1 while the FIFO is full and no transfer occurs, the pixel SHALL be discarded and overflow_o SHALL be set on the next cycle.
REQ-018 The FIFO SHALL be show-ahead: valid_o = (level_o != 0), and data_o is always the oldest stored pixel.
REQ-019 Latency: a pixel pushed into an empty FIFO in cycle N SHALL appear on data_o with valid_o=1 in cycle N+1.
REQ-020 When the FIFO is empty, a pixel SHALL NOT bypass the buffer in the same cycle.
REQ-021 Simultaneous push and transfer SHALL leave level_o unchanged, including at full and at level 1.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with no gap or duplicate at the wrap.
REQ-023 data_o and valid_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-024 Column counter col (0..IMG_W-1) SHALL advance on each transfer; it wraps to 0 after IMG_W-1 and then advances the row counter.
REQ-025 Row counter row (0..IMG_H-1) SHALL wrap to 0 after the last pixel of the frame.
REQ-026 Counters SHALL change on transfers only; pushes and drops SHALL NOT affect them.
REQ-027 sof_o SHALL equal valid_o when col=0 and row=0.
REQ-028 eol_o SHALL equal valid_o when col=IMG_W-1.
REQ-029 eof_o SHALL equal valid_o when col=IMG_W-1 and row=IMG_H-1; eol_o is also 1 in that case.
REQ-030 Frame-position state machine: states SOF_WAIT, IN_FRAME and LAST_LINE.
REQ-031 SOF_WAIT goes to IN_FRAME on the first transfer.
REQ-032 IN_FRAME goes to LAST_LINE when row becomes IMG_H-1.
REQ-033 LAST_LINE goes to SOF_WAIT on the transfer that carries eof_o.
REQ-034 The flags SHALL be derived combinationally from the counters and valid_o, with no added latency.
REQ-035 overflow_o SHALL remain set until srst_i; dropped pixels SHALL NOT disturb the counters or the stored data.

Reset
REQ-036 With srst_i=1 at a clock edge, the block SHALL clear level_o to 0, valid_o, sof_o, eol_o, eof_o, almost_full_o and overflow_o to 0, and the pointers, col and row to 0, with the state machine in SOF_WAIT.
REQ-037 data_o after reset SHALL be don't-care while valid_o=0; a pixel_valid_i input during reset SHALL be ignored.
REQ-038 Reset asserted mid-frame SHALL discard all buffered pixels; the first transfer after reset SHALL carry sof_o=1.

Verification (IMG_W=4, IMG_H=2, FIFO_DEPTH=4, DATA_W=8)
REQ-039 Basic flow: push 0x01..0x08 one per cycle with ready_i=1 -> outputs 0x01..0x08 in order, each one cycle after its push; sof_o on 0x01, eol_o on 0x04 and 0x08, eof_o on 0x08 only.
REQ-040 Backpressure: ready_i=0 while pushing 0x10..0x13 -> level_o=4, almost_full_o=1, data_o held at 0x10; then ready_i=1 -> 0x10..0x13 emitted in order.
REQ-041 Overflow: FIFO full with ready_i=0, push 0x55 -> level_o stays 4, overflow_o=1 next cycle and stays set; 0x55 is never emitted.
REQ-042 Full with simultaneous push/pop: level 4, ready_i=1 and push 0xAA in the same cycle -> level_o stays 4, overflow_o stays 0, 0xAA is emitted after the three older pixels.
REQ-043 Wrap: stream 3 frames of 8 pixels through the FIFO (multiple pointer wraps) -> sof_o on pixels 1, 9 and 17; eof_o on pixels 8, 16 and 24.
REQ-044 Reset mid-frame: after 5 transfers assert srst_i for 1 cycle with 2 pixels buffered -> valid_o=0 and level_o=0; the next pushed pixel is emitted with sof_o=1.

Source files
------------

// File: rtl/pixel_stream_out.sv
// pixel_stream_out: output buffer for a pixel stream with frame markers.
//   A show-ahead FIFO absorbs pixels from a source that cannot be stalled.
//   Column and row counters track the frame position of the head pixel so
//   that start-of-frame, end-of-line and end-of-frame can be flagged on the
//   same cycle the pixel is presented.
// Ports:
//   clk_i, srst_i             clock, synchronous active-high reset
//   pixel_data_i/valid_i      incoming pixels (no backpressure)
//   data_o/valid_o/ready_i    outgoing handshake; transfer = valid_o & ready_i
//   sof_o/eol_o/eof_o         frame markers qualified by valid_o
//   level_o, almost_full_o    FIFO occupancy, high at FIFO_DEPTH-2 or more
//   overflow_o                sticky, set after a pixel was dropped
module pixel_stream_out #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic [DATA_W-1:0]             pixel_data_i,
  input  logic                          pixel_valid_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          sof_o,
  output logic                          eol_o,
  output logic                          eof_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          almost_full_o,
  output logic                          overflow_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef enum logic [1:0] {SOF_WAIT, IN_FRAME, LAST_LINE} state_e;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              overflow_q, overflow_d;
  state_e            state_q, state_d;

  logic full, xfer, push, drop, last_col, last_row;

  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign valid_o  = (level_q != '0);
  assign xfer     = valid_o & ready_i;
  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign push     = pixel_valid_i & (~full | xfer);
  assign drop     = pixel_valid_i & full & ~xfer;
  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));

  assign data_o        = mem_q[rd_ptr_q];
  assign level_o       = level_q;
  assign almost_full_o = (level_q >= LVL_W'(FIFO_DEPTH - 2));
  assign overflow_o    = overflow_q;
  assign sof_o         = valid_o & (col_q == '0) & (row_q == '0);
  assign eol_o         = valid_o & last_col;
  assign eof_o         = valid_o & last_col & last_row;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    col_d      = col_q;
    row_d      = row_q;
    overflow_d = overflow_q | drop;
    state_d    = state_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (xfer) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, xfer})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Frame position follows the consumer side only.
    if (xfer) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case (state_q)
      SOF_WAIT:  if (xfer) state_d = IN_FRAME;
      // Look at row_d so the last line is recognised even when IMG_W is small.
      IN_FRAME:  if (row_d == ROW_W'(IMG_H - 1)) state_d = LAST_LINE;
      LAST_LINE: if (xfer && last_col && last_row) state_d = SOF_WAIT;
      default:   state_d = SOF_WAIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
      state_q    <= SOF_WAIT;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      col_q      <= col_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // Storage is not reset; contents are don't-care while valid_o is low.
  always_ff @(posedge clk_i) begin
    if (push && !srst_i) mem_q[wr_ptr_q] <= pixel_data_i;
  end

endmodule
